// File: rtl/stopwatch_counter.sv
// BCD mm:ss stopwatch with run/pause toggle, 1 Hz counting and a 2 Hz
// per-field adjust mode; wrap pulses for one cycle on a counting rollover.
module stopwatch_counter #(
    parameter int MIN_LIMIT = 59
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       pause_btn,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       wrap
);

    localparam logic [3:0] MIN_T = 4'(MIN_LIMIT / 10);
    localparam logic [3:0] MIN_O = 4'(MIN_LIMIT % 10);

    typedef enum logic {
        PAUSED = 1'b0,
        RUN    = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] mt_d, mo_d, st_d, so_d;
    logic       wrap_d;
    logic       sec_max, min_max, count_en, inc_sec, inc_min;

    assign sec_max  = (sec_tens == 4'd5) && (sec_ones == 4'd9);
    assign min_max  = (min_tens == MIN_T) && (min_ones == MIN_O);
    assign count_en = !adj && (state_q == RUN) && tick_1hz;

    // Adjust bumps one field with no carry; counting carries seconds into minutes.
    assign inc_sec = adj ? (tick_2hz && sel)  : count_en;
    assign inc_min = adj ? (tick_2hz && !sel) : (count_en && sec_max);

    always_comb begin
        state_d = state_q;
        mt_d    = min_tens;
        mo_d    = min_ones;
        st_d    = sec_tens;
        so_d    = sec_ones;
        wrap_d  = 1'b0;

        if (pause_btn) begin
            state_d = (state_q == RUN) ? PAUSED : RUN;
        end

        if (inc_sec) begin
            if (sec_ones == 4'd9) begin
                so_d = 4'd0;
                st_d = (sec_tens == 4'd5) ? 4'd0 : sec_tens + 4'd1;
            end else begin
                so_d = sec_ones + 4'd1;
            end
        end

        if (inc_min) begin
            if (min_max) begin
                mt_d = 4'd0;
                mo_d = 4'd0;
            end else if (min_ones == 4'd9) begin
                mo_d = 4'd0;
                mt_d = min_tens + 4'd1;
            end else begin
                mo_d = min_ones + 4'd1;
            end
        end

        wrap_d = count_en && sec_max && min_max;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q  <= PAUSED;
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
            wrap     <= 1'b0;
        end else begin
            state_q  <= state_d;
            min_tens <= mt_d;
            min_ones <= mo_d;
            sec_tens <= st_d;
            sec_ones <= so_d;
            wrap     <= wrap_d;
        end
    end

    assign running = (state_q == RUN);

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: drivers push expected
// {running, wrap, mm, ss} into a queue and a negedge monitor compares.
module tb_stopwatch_counter;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       tick_2hz = 1'b0;
    logic       pause_btn = 1'b0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, wrap;

    logic [17:0] exp_q[$];
    string       name_q[$];
    int          n_total = 0;
    int          n_pass = 0;

    stopwatch_counter #(.MIN_LIMIT(59)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .tick_1hz  (tick_1hz),
        .tick_2hz  (tick_2hz),
        .pause_btn (pause_btn),
        .adj       (adj),
        .sel       (sel),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .running   (running),
        .wrap      (wrap)
    );

    // clock / watchdog
    always #5 clk_in = ~clk_in;

    initial begin
        #200us;
        $display("FAIL watchdog: bench did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [17:0] ev(input logic r, input logic w, input int m, input int s);
        return {r, w, 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    // driver tasks
    task automatic cyc(input logic t1, input logic t2, input logic pb);
        tick_1hz  = t1;
        tick_2hz  = t2;
        pause_btn = pb;
        @(posedge clk_in);
        #1;
        tick_1hz  = 1'b0;
        tick_2hz  = 1'b0;
        pause_btn = 1'b0;
    endtask

    task automatic chk(input logic [17:0] e, input string name);
        exp_q.push_back(e);
        name_q.push_back(name);
        @(negedge clk_in);
        #1;
    endtask

    task automatic adj_ticks(input logic s, input int n);
        adj = 1'b1;
        sel = s;
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        adj = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    // scoreboard monitor
    always @(negedge clk_in) begin
        if (exp_q.size() != 0) begin
            logic [17:0] e, a;
            string       n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = {running, wrap, min_tens, min_ones, sec_tens, sec_ones};
            n_total++;
            if (a === e) n_pass++;
            else $display("FAIL %s: actual run=%b wrap=%b %h%h:%h%h required run=%b wrap=%b %h%h:%h%h",
                          n, a[17], a[16], a[15:12], a[11:8], a[7:4], a[3:0],
                          e[17], e[16], e[15:12], e[11:8], e[7:4], e[3:0]);
        end
    end

    initial begin
        // reset held while every other input pulses
        cyc(1'b1, 1'b1, 1'b1);
        chk(ev(0, 0, 0, 0), "reset_state");
        rst = 1'b0;

        // start and count ten seconds, covering the ones->tens carry
        cyc(1'b0, 1'b0, 1'b1);
        chk(ev(1, 0, 0, 0), "start_run");
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            chk(ev(1, 0, 0, i), "count_sec");
        end

        // 00:59 -> 01:00 minute carry, no wrap
        do_reset();
        adj_ticks(1'b1, 59);
        adj = 1'b0;
        chk(ev(0, 0, 0, 59), "preload_0059");
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        chk(ev(1, 0, 1, 0), "carry_min");

        // 59:59 -> 00:00 with a single-cycle wrap pulse
        do_reset();
        adj_ticks(1'b0, 59);
        adj_ticks(1'b1, 59);
        adj = 1'b0;
        chk(ev(0, 0, 59, 59), "preload_5959");
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        chk(ev(1, 1, 0, 0), "wrap_pulse");
        cyc(1'b0, 1'b0, 1'b0);
        chk(ev(1, 0, 0, 0), "wrap_clear");

        // adjust mode: field wraps without carry, tick_1hz ignored
        do_reset();
        adj_ticks(1'b1, 58);
        cyc(1'b0, 1'b0, 1'b1);
        chk(ev(1, 0, 0, 58), "pause_in_adj");
        cyc(1'b1, 1'b0, 1'b0);
        chk(ev(1, 0, 0, 58), "tick1_in_adj");
        cyc(1'b0, 1'b1, 1'b0);
        chk(ev(1, 0, 0, 59), "adj_sec_59");
        cyc(1'b0, 1'b1, 1'b0);
        chk(ev(1, 0, 0, 0), "adj_sec_wrap");
        cyc(1'b0, 1'b1, 1'b0);
        chk(ev(1, 0, 0, 1), "adj_sec_01");
        cyc(1'b1, 1'b1, 1'b0);
        chk(ev(1, 0, 0, 2), "adj_both_ticks");
        adj_ticks(1'b0, 59);
        chk(ev(1, 0, 59, 2), "adj_min_59");
        cyc(1'b0, 1'b1, 1'b0);
        chk(ev(1, 0, 0, 2), "adj_min_wrap");
        adj = 1'b0;

        // pause and tick in the same cycle: tick counts, then paused
        do_reset();
        adj_ticks(1'b1, 10);
        adj = 1'b0;
        cyc(1'b0, 1'b0, 1'b1);
        chk(ev(1, 0, 0, 10), "run_0010");
        cyc(1'b1, 1'b0, 1'b1);
        chk(ev(0, 0, 0, 11), "pause_with_tick");
        cyc(1'b1, 1'b0, 1'b0);
        chk(ev(0, 0, 0, 11), "paused_hold_a");
        cyc(1'b1, 1'b0, 1'b0);
        chk(ev(0, 0, 0, 11), "paused_hold_b");

        // reset beats simultaneous tick and pause at 12:34
        do_reset();
        adj_ticks(1'b0, 12);
        adj_ticks(1'b1, 34);
        adj = 1'b0;
        cyc(1'b0, 1'b0, 1'b1);
        chk(ev(1, 0, 12, 34), "run_1234");
        rst = 1'b1;
        cyc(1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        chk(ev(0, 0, 0, 0), "rst_priority");
        cyc(1'b1, 1'b0, 1'b0);
        chk(ev(0, 0, 0, 0), "post_rst_paused");
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        chk(ev(1, 0, 0, 1), "resume_after_rst");

        // drain, then report
        repeat (4) @(negedge clk_in);
        #1;
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 SHALL have parameter MIN_LIMIT, default 59, highest minutes value before wrap to 00 (legal 1..59).
REQ-002 SHALL have port clk_in  input  1  100 MHz system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port tick_1hz  input  1  one-cycle enable pulse, 1 Hz, from the clock divider.
REQ-005 SHALL have port tick_2hz  input  1  one-cycle enable pulse, 2 Hz, from the clock divider.
REQ-006 SHALL have port pause_btn  input  1  one-cycle pulse (already debounced); toggles run/pause.
REQ-007 SHALL have port adj  input  1  level; 1 = adjust mode.
REQ-008 SHALL have port sel  input  1  level; adjust target, 0 = minutes, 1 = seconds.
REQ-009 SHALL have ports min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD time digits.
REQ-010 SHALL have port running  output  1  1 when state is RUN.
REQ-011 SHALL have port wrap  output  1  one-cycle pulse when time wraps MIN_LIMIT:59 -> 00:00.

Function
REQ-012 SHALL implement two states, PAUSED and RUN; pause_btn=1 toggles state, taking effect next cycle.
REQ-013 SHALL evaluate each cycle with priority: rst > adj > tick_1hz count; pause_btn toggles regardless of adj.
REQ-014 SHALL, in RUN with adj=0 and tick_1hz=1, add one second to the time in that clock edge (outputs update 1 cycle after tick).
REQ-015 SHALL use the current (pre-toggle) state when pause_btn and tick_1hz coincide.
REQ-016 SHALL hold time unchanged in PAUSED with adj=0, ignoring tick_1hz.
REQ-017 SHALL count seconds 00..59 in BCD: sec_ones 9 -> 0 carries into sec_tens; sec_tens 5 with sec_ones 9 -> 00 carries one minute.
REQ-018 SHALL count minutes 00..MIN_LIMIT in BCD; minute carry at MIN_LIMIT -> 00 with wrap=1 for exactly the following cycle.
REQ-019 SHALL, when adj=1 (either state), ignore tick_1hz and on each tick_2hz increment only the selected field by one.
REQ-020 SHALL wrap an adjusted field independently (seconds 59 -> 00, minutes MIN_LIMIT -> 00) with no carry and wrap=0.
REQ-021 SHALL never present a non-BCD digit (values 10..15) on any digit output.
REQ-022 SHALL keep wrap=0 in every cycle not immediately following a counting rollover.
REQ-023 SHALL leave running reflecting state only, independent of adj.

Reset
REQ-024 SHALL on rst=1 at a clock edge set all digits to 0, state PAUSED, running=0, wrap=0.
REQ-025 SHALL give rst priority over simultaneous tick_1hz, tick_2hz and pause_btn; none of them affect state on that edge.
REQ-026 SHALL abort any count or adjust in progress when rst asserts mid-operation; no partial carry persists.
REQ-027 SHALL resume normal behaviour on the first edge with rst=0.

Verification
REQ-028 SHALL cover: reset, pause_btn pulse, 5 tick_1hz pulses -> running=1, time 00:05.
REQ-029 SHALL cover: preload 00:59 via adjust, RUN, one tick_1hz -> 01:00, wrap=0.
REQ-030 SHALL cover: preload 59:59 (MIN_LIMIT=59), RUN, one tick_1hz -> 00:00 and wrap=1 for exactly one cycle.
REQ-031 SHALL cover: adj=1, sel=1, time 00:58, 3 tick_2hz -> 00:01, minutes unchanged, wrap=0; tick_1hz during adj ignored.
REQ-032 SHALL cover: RUN at 00:10, pause_btn and tick_1hz same cycle -> 00:11 then running=0; further tick_1hz hold 00:11.
REQ-033 SHALL cover: RUN at 12:34, rst with simultaneous tick_1hz and pause_btn -> 00:00, running=0, wrap=0.
